// File: rtl/rf_trace_monitor.sv
// -----------------------------------------------------------------------------
// rf_trace_monitor
//
// Periodically snapshots the program counter and a set of register-file words,
// timestamps each snapshot with the cycle count since reset, and queues the
// records in a FIFO. The FIFO drains through a valid/ready stream to a UART or
// debug sink. Sampling stops after MAX_CYCLES cycles and `done` is raised.
//
// Optional feature (macro TRACE_CHANGE_ONLY_EN):
//   When the macro is defined, a snapshot is skipped if the PC and all captured
//   registers equal the last record that was queued. The first snapshot after
//   reset is always queued. When the macro is undefined, every snapshot tries
//   to enter the FIFO and the comparison registers are not built.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   enable       sampling enable
//   pc_in        current program counter
//   rf_flat      register i on bits [i*DATA_W +: DATA_W]
//   trace_data   head record {timestamp, pc, rf_flat}, timestamp in the MSBs
//   trace_valid  FIFO not empty
//   trace_ready  sink accepts the head record
//   done         run finished (cycle counter has reached MAX_CYCLES)
//   drop_cnt     snapshots lost to a full FIFO, saturating at 255
// -----------------------------------------------------------------------------
module rf_trace_monitor #(
  parameter int DATA_W        = 16,
  parameter int PC_W          = 13,
  parameter int NREG          = 8,
  parameter int DEPTH         = 8,
  parameter int SAMPLE_PERIOD = 2,
  parameter int TS_W          = 16,
  parameter int MAX_CYCLES    = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [PC_W-1:0]                  pc_in,
  input  logic [NREG*DATA_W-1:0]           rf_flat,
  output logic [TS_W+PC_W+NREG*DATA_W-1:0] trace_data,
  output logic                             trace_valid,
  input  logic                             trace_ready,
  output logic                             done,
  output logic [7:0]                       drop_cnt
);

  localparam int REC_W = TS_W + PC_W + NREG * DATA_W;
  localparam int RF_W  = NREG * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [TS_W-1:0]  MAX_TS   = TS_W'(MAX_CYCLES);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TS_W-1:0]  cycle_cnt;
  logic [PER_W-1:0] period_cnt;
  logic             active;
  logic             strobe;
  logic             strobe_eff;
  logic [REC_W-1:0] rec;

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;

  // ---------------------------------------------------------------------------
  // Run timer and sample-period divider
  // ---------------------------------------------------------------------------
  assign active = enable & ~done;
  assign strobe = active & (period_cnt == PER_LAST);
  assign rec    = {cycle_cnt, pc_in, rf_flat};

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      period_cnt <= '0;
      done       <= 1'b0;
    end else begin
      if (cycle_cnt != MAX_TS) begin
        cycle_cnt <= cycle_cnt + TS_W'(1);
      end
      // done goes high on the same edge that brings cycle_cnt to MAX_CYCLES.
      done <= (cycle_cnt == MAX_TS) || (cycle_cnt + TS_W'(1) == MAX_TS);
      if (active) begin
        period_cnt <= (period_cnt == PER_LAST) ? '0 : period_cnt + PER_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot filter
  // ---------------------------------------------------------------------------
`ifdef TRACE_CHANGE_ONLY_EN
  logic            have_last;
  logic [PC_W-1:0] last_pc;
  logic [RF_W-1:0] last_rf;

  // The comparison copy follows only records that actually entered the FIFO,
  // so a snapshot dropped on a full FIFO is retried at the next strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_last <= 1'b0;
      last_pc   <= '0;
      last_rf   <= '0;
    end else if (push) begin
      have_last <= 1'b1;
      last_pc   <= pc_in;
      last_rf   <= rf_flat;
    end
  end

  assign strobe_eff = strobe & ~(have_last && (pc_in == last_pc) && (rf_flat == last_rf));
`else
  assign strobe_eff = strobe;
`endif

  // ---------------------------------------------------------------------------
  // FIFO with a registered head (first-word-fall-through)
  // ---------------------------------------------------------------------------
  assign trace_valid = (count != '0);
  assign full        = (count == FULL_CNT);
  assign pop         = trace_valid & trace_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign push        = strobe_eff & (~full | pop);
  assign rd_ptr_inc  = rd_ptr + PTR_W'(1);

  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, and the head register provides the reset value.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      trace_data <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (strobe_eff && full && !pop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      // The head register mirrors mem[rd_ptr]. A record entering an empty (or
      // emptying) FIFO bypasses the array so it is visible one cycle later.
      if (pop) begin
        if (count == CNT_W'(1)) begin
          trace_data <= push ? rec : '0;
        end else begin
          trace_data <= mem[rd_ptr_inc];
        end
      end else if (!trace_valid && push) begin
        trace_data <= rec;
      end
    end
  end

endmodule

// File: tb/tb_rf_trace_monitor.sv
// -----------------------------------------------------------------------------
// tb_rf_trace_monitor
//
// Self-checking bench for rf_trace_monitor with default parameters. Each cycle
// the reference model decides from plain arithmetic whether a snapshot is due,
// keeps the expected FIFO contents in a queue, and the DUT outputs are compared
// against it. Directed runs cover the listed scenarios; randomized runs follow.
// -----------------------------------------------------------------------------
module tb_rf_trace_monitor;

  localparam int DATA_W = 16;
  localparam int PC_W   = 13;
  localparam int NREG   = 8;
  localparam int DEPTH  = 8;
  localparam int SP     = 2;
  localparam int TS_W   = 16;
  localparam int MAXC   = 20;
  localparam int RF_W   = NREG * DATA_W;
  localparam int REC_W  = TS_W + PC_W + RF_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [PC_W-1:0]  pc_in = '0;
  logic [RF_W-1:0]  rf_flat = '0;
  logic [REC_W-1:0] trace_data;
  logic             trace_valid;
  logic             trace_ready = 1'b0;
  logic             done;
  logic [7:0]       drop_cnt;

  always #5 clk = ~clk;

  rf_trace_monitor #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG), .DEPTH(DEPTH),
    .SAMPLE_PERIOD(SP), .TS_W(TS_W), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pc_in(pc_in), .rf_flat(rf_flat),
    .trace_data(trace_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .done(done), .drop_cnt(drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int               m_t;        // cycles elapsed since reset release, capped
  int               m_en;       // enabled, not-done cycles since reset release
  int               m_drops;
  logic [REC_W-1:0] m_q[$];
  int               popped_ts[$];
`ifdef TRACE_CHANGE_ONLY_EN
  bit               m_have;
  logic [PC_W-1:0]  m_pc;
  logic [RF_W-1:0]  m_rf;
`endif

  function automatic logic [RF_W-1:0] rf_ramp();
    logic [RF_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) r[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
    return r;
  endfunction

  task automatic model_reset();
    m_t = 0;
    m_en = 0;
    m_drops = 0;
    m_q.delete();
    popped_ts.delete();
`ifdef TRACE_CHANGE_ONLY_EN
    m_have = 1'b0;
`endif
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", trace_valid, 1'b0);
    check("rst_data", trace_data, '0);
    check("rst_done", done, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic step(input bit en, input bit rdy, input logic [PC_W-1:0] pc,
                      input logic [RF_W-1:0] rf);
    bit               stb;
    bit               pop_m;
    bit               push_m;
    logic [REC_W-1:0] r;
    enable = en;
    trace_ready = rdy;
    pc_in = pc;
    rf_flat = rf;
    #1;
    if (trace_valid && trace_ready) popped_ts.push_back(int'(trace_data[REC_W-1 -: TS_W]));

    stb = en && (m_t < MAXC) && ((m_en % SP) == SP - 1);
`ifdef TRACE_CHANGE_ONLY_EN
    if (stb && m_have && pc == m_pc && rf == m_rf) stb = 1'b0;
`endif
    r = {TS_W'(m_t), pc, rf};
    pop_m  = (m_q.size() > 0) && rdy;
    push_m = stb && ((m_q.size() < DEPTH) || pop_m);
    if (stb && !push_m && m_drops < 255) m_drops++;
    if (pop_m) void'(m_q.pop_front());
    if (push_m) begin
      m_q.push_back(r);
`ifdef TRACE_CHANGE_ONLY_EN
      m_have = 1'b1;
      m_pc = pc;
      m_rf = rf;
`endif
    end
    if (en && m_t < MAXC) m_en++;
    if (m_t < MAXC) m_t++;

    @(posedge clk);
    #1;
    check("valid", trace_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("data", trace_data, m_q[0]);
    check("done", done, m_t == MAXC);
    check("drop", drop_cnt, 8'(m_drops));
  endtask

  task automatic check_ts(input string tag, input int exp[$]);
    check({tag, "_count"}, 32'(popped_ts.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < popped_ts.size(); i++)
      check({tag, "_ts"}, 32'(popped_ts[i]), 32'(exp[i]));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int              exp_ts[$];
    logic [RF_W-1:0] rf_r;
    logic [PC_W-1:0] pc_r;

    // Free-running trace: timestamps 1,3,...,19.
    do_reset();
    for (int c = 0; c < 24; c++) step(1'b1, 1'b1, PC_W'(5), rf_ramp());
    exp_ts.delete();
    for (int j = 0; j < 10; j++) exp_ts.push_back(2 * j + 1);
    check_ts("run", exp_ts);
    check("run_drop", drop_cnt, 8'd0);
    check("run_done", done, 1'b1);

    // Back-pressured sink: 8 buffered, 2 dropped, then in-order drain.
    do_reset();
    for (int c = 0; c < 22; c++) step(1'b1, 1'b0, PC_W'(5), rf_ramp());
    check("bp_drop", drop_cnt, 8'd2);
    check("bp_valid", trace_valid, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1, PC_W'(5), rf_ramp());
    exp_ts.delete();
    for (int j = 0; j < 8; j++) exp_ts.push_back(2 * j + 1);
    check_ts("drain", exp_ts);
    check("drain_valid", trace_valid, 1'b0);

    // Enable gap over cycles 4..9.
    do_reset();
    for (int c = 0; c < 24; c++) step(!(c >= 4 && c <= 9), 1'b1, PC_W'(5), rf_ramp());
    exp_ts.delete();
    exp_ts.push_back(1);
    exp_ts.push_back(3);
    for (int j = 11; j < MAXC; j += 2) exp_ts.push_back(j);
    check_ts("gap", exp_ts);

    // Mid-run asynchronous reset with 3 records buffered, then restart.
    do_reset();
    for (int c = 0; c < 7; c++) step(1'b1, 1'b0, PC_W'(5), rf_ramp());
    check("pre_rst_valid", trace_valid, 1'b1);
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, PC_W'(5), rf_ramp());
    exp_ts.delete();
    exp_ts.push_back(1);
    check_ts("restart", exp_ts);

    // Full FIFO with a pop on the strobe edge: accepted, no drop.
    do_reset();
    for (int c = 0; c < 17; c++) step(1'b1, 1'b0, PC_W'(5), rf_ramp());
    step(1'b1, 1'b1, PC_W'(5), rf_ramp());
    check("full_pop_drop", drop_cnt, 8'd0);
    step(1'b1, 1'b0, PC_W'(5), rf_ramp());
    step(1'b1, 1'b0, PC_W'(5), rf_ramp());
    check("full_nopop_drop", drop_cnt, 8'd1);
    for (int c = 0; c < 12; c++) step(1'b1, 1'b1, PC_W'(5), rf_ramp());

`ifdef TRACE_CHANGE_ONLY_EN
    // Change-only: register 3 changes once at cycle 10.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      rf_r = rf_ramp();
      if (c >= 10) rf_r[3*DATA_W +: DATA_W] = DATA_W'(100);
      step(1'b1, 1'b1, PC_W'(5), rf_r);
    end
    exp_ts.delete();
    exp_ts.push_back(1);
    exp_ts.push_back(11);
    check_ts("chg", exp_ts);
    check("chg_drop", drop_cnt, 8'd0);
`endif

    // Randomized runs.
    for (int run = 0; run < 6; run++) begin
      do_reset();
      rf_r = rf_ramp();
      pc_r = PC_W'(5);
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 3) == 0) pc_r = PC_W'($urandom);
        if ($urandom_range(0, 4) == 0) rf_r[$urandom_range(0, NREG - 1)*DATA_W +: DATA_W] = DATA_W'($urandom);
        step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, pc_r, rf_r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_trace_monitor.md
Name: rf_trace_monitor

Overview:
- Synthesizable successor to the processor bench's periodic PC/register-file printout.
- Snapshots the PC and a parametrised set of register-file words every SAMPLE_PERIOD cycles and timestamps each snapshot.
- Buffers snapshots in a FIFO and streams them out over a valid/ready port to a UART/debug sink.
- Stops sampling after MAX_CYCLES and raises done, the hardware equivalent of the bench's end-of-run.

Parameters:
- DATA_W, 16, register width.
- PC_W, 13, program-counter width.
- NREG, 8, number of registers captured per snapshot (flattened input).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SAMPLE_PERIOD, 2, cycles between snapshots; >= 1.
- TS_W, 16, timestamp width.
- MAX_CYCLES, 20, run length in cycles; must be < 2^TS_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable.
- pc_in  in  PC_W  current PC.
- rf_flat  in  NREG*DATA_W  register i on bits [i*DATA_W +: DATA_W].
- trace_data  out  TS_W+PC_W+NREG*DATA_W  record {timestamp, pc, rf_flat}, timestamp in MSBs.
- trace_valid  out  1  FIFO not empty.
- trace_ready  in  1  sink accepts the head record.
- done  out  1  run finished.
- drop_cnt  out  8  snapshots lost to a full FIFO; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous):
  - cycle_cnt=0, period_cnt=0, FIFO empty.
  - trace_valid=0, trace_data=0, done=0, drop_cnt=0.
  - Reset mid-run flushes all buffered records.
- cycle_cnt:
  - Increments every cycle after reset release until it equals MAX_CYCLES, then holds.
  - done is registered: it is 1 exactly when cycle_cnt==MAX_CYCLES.
- period_cnt:
  - Advances only while enable=1 and done=0.
  - Wraps from SAMPLE_PERIOD-1 to 0.
  - When enable=0 it holds its value; no strobe is generated.
- Strobe: asserted in cycle k when enable=1, done=0 and period_cnt==SAMPLE_PERIOD-1.
  - The record {cycle_cnt, pc_in, rf_flat} is sampled in cycle k.
  - It is pushed on the edge that ends cycle k.
- Latency: a record pushed into an empty FIFO appears on trace_data with trace_valid=1 in cycle k+1 (first-word-fall-through, registered head).
- Pop occurs on an edge where trace_valid=1 and trace_ready=1.
- trace_data holds stable while trace_valid=1 and trace_ready=0.
- Full FIFO:
  - A strobe without a simultaneous pop is dropped and drop_cnt increments (saturating).
  - A strobe with a simultaneous pop is accepted; occupancy is unchanged.
- Empty FIFO with a simultaneous strobe: the push happens; trace_ready has no effect while trace_valid=0.
- Pointers wrap modulo DEPTH; occupancy counter width is clog2(DEPTH)+1.
- After done=1:
  - No new strobes.
  - The FIFO continues to drain normally.
  - done and drop_cnt hold until reset.

Optional Feature:
- Macro: TRACE_CHANGE_ONLY_EN.
- Defined:
  - A strobe is suppressed when pc_in and rf_flat both equal the last pushed record's values.
  - The first strobe after reset is always pushed.
  - Suppressed strobes do not touch drop_cnt.
  - A dropped (full-FIFO) strobe does not update the comparison copy.
- Undefined: every strobe attempts a push; the comparison registers are not built.

Test Plan:
- Defaults, enable=1, trace_ready=1, pc_in=5, register i = i+1 -> 10 records with timestamps 1,3,...,19; each has pc=5 and reg0=1..reg7=8; done=1 from cycle 20; drop_cnt=0.
- Defaults, trace_ready=0 throughout -> 8 records buffered (timestamps 1..15), drop_cnt=2; then trace_ready=1 -> 8 pops in order, trace_valid falls after the 8th pop.
- enable=0 during cycles 4..9, otherwise as the first case -> no records with timestamps 5, 7 or 9; the next record after re-enable has timestamp 11.
- rst pulsed low in cycle 8 with 3 records buffered -> trace_valid=0 and all outputs 0 immediately (asynchronous); after release, timestamps restart at 1.
- Full FIFO with trace_ready=1 on the same edge as a strobe -> record accepted, occupancy stays 8, drop_cnt unchanged.
- TRACE_CHANGE_ONLY_EN defined, pc_in constant=5, register 3 changed once at cycle 10 -> exactly 2 records (timestamps 1 and 11); drop_cnt=0.
